// File: rtl/cache_fill_fsm_if.sv
// Cache-miss fill bundle: miss request in, memory read/return, cache array writes out.
// master is the fill controller; slave is the cache/memory side.
interface cache_fill_fsm_if;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        fsm_busy;
  logic        memory_read;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [2:0]  data_array_word;
  logic [15:0] cache_data;
  logic        write_tag_array;
  logic [11:0] fill_line;

  modport master (
    input  miss_detected, miss_address, memory_data_valid, memory_data,
    output fsm_busy, memory_read, memory_address, write_data_array,
           data_array_word, cache_data, write_tag_array, fill_line
  );

  modport slave (
    output miss_detected, miss_address, memory_data_valid, memory_data,
    input  fsm_busy, memory_read, memory_address, write_data_array,
           data_array_word, cache_data, write_tag_array, fill_line
  );
endinterface

// File: rtl/cache_fill_fsm.sv
// Cache line fill: 8 pipelined word reads, data-array write per returned word, tag write with the last word.
// Busy from cycle after miss until the 8th word lands; return timing is driven purely by memory_data_valid.
module cache_fill_fsm #(
  parameter int LINE_WORDS = 8
) (
  input  logic             clk,
  input  logic             rst,
  cache_fill_fsm_if.master bus
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_FILL = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [2:0]  issue_cnt_q, issue_cnt_d;
  logic [2:0]  recv_cnt_q, recv_cnt_d;
  logic        issue_done_q, issue_done_d;
  logic [11:0] fill_line_q, fill_line_d;

  logic in_fill;
  logic last_word;

  assign in_fill   = (state_q == S_FILL);
  assign last_word = in_fill && bus.memory_data_valid && (recv_cnt_q == 3'(LINE_WORDS - 1));

  always_comb begin
    state_d      = state_q;
    issue_cnt_d  = issue_cnt_q;
    recv_cnt_d   = recv_cnt_q;
    issue_done_d = issue_done_q;
    fill_line_d  = fill_line_q;

    case (state_q)
      S_IDLE: begin
        if (bus.miss_detected) begin
          fill_line_d  = bus.miss_address[15:4];
          issue_cnt_d  = 3'd0;
          recv_cnt_d   = 3'd0;
          issue_done_d = 1'b0;
          state_d      = S_FILL;
        end
      end
      default: begin
        if (!issue_done_q) begin
          issue_cnt_d = issue_cnt_q + 3'd1;
          if (issue_cnt_q == 3'd7) begin
            issue_done_d = 1'b1;
          end
        end
        if (bus.memory_data_valid) begin
          recv_cnt_d = recv_cnt_q + 3'd1;
        end
        // Words come back in issue order, so the 8th valid closes the fill.
        if (last_word) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      issue_cnt_q  <= 3'd0;
      recv_cnt_q   <= 3'd0;
      issue_done_q <= 1'b0;
      fill_line_q  <= 12'h000;
    end else begin
      state_q      <= state_d;
      issue_cnt_q  <= issue_cnt_d;
      recv_cnt_q   <= recv_cnt_d;
      issue_done_q <= issue_done_d;
      fill_line_q  <= fill_line_d;
    end
  end

  always_comb begin
    bus.fsm_busy         = in_fill;
    bus.memory_read      = in_fill && !issue_done_q;
    bus.memory_address   = 16'h0000;
    bus.write_data_array = in_fill && bus.memory_data_valid;
    bus.data_array_word  = 3'd0;
    bus.cache_data       = bus.memory_data;
    bus.write_tag_array  = last_word;
    bus.fill_line        = fill_line_q;
    if (in_fill && !issue_done_q) begin
      bus.memory_address = {fill_line_q, issue_cnt_q, 1'b0};
    end
    if (in_fill && bus.memory_data_valid) begin
      bus.data_array_word = recv_cnt_q;
    end
  end

endmodule
